// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM states and counter sizing for the E-stage MDU
// Codes 9-12 are only decoded when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_t;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Wide enough to hold the larger latency as a down-counter start value.
  function automatic int lat_w(input int mult_lat, input int div_lat);
    int mx;
    mx = (mult_lat > div_lat) ? mult_lat : div_lat;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/mdu_core_calc.sv
// rtl/mdu_core_calc.sv - combinational HI/LO result for one MDU op (MDU_MADD_EN adds accumulate ops)
// Ops that produce no result (NOP, divide by zero, moves) pass the current HI/LO through.
module mdu_core_calc
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] hi_cur,
  input  logic [DATA_W-1:0] lo_cur,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic [DATA_W-1:0]   sq, sr;
  logic                b_zero, s_ovf;

  assign prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign sq     = $signed(a) / $signed(b);
  assign sr     = $signed(a) % $signed(b);
  assign b_zero = (b == '0);
  assign s_ovf  = (a == SMIN) && (b == '1);

  always_comb begin
    res_hi = hi_cur;
    res_lo = lo_cur;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (s_ovf) begin
          res_hi = '0;
          res_lo = SMIN;
        end else if (!b_zero) begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      OP_DIVU: begin
        if (!b_zero) begin
          res_hi = a % b;
          res_lo = a / b;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {res_hi, res_lo} = {hi_cur, lo_cur} + prod_s;
      OP_MADDU: {res_hi, res_lo} = {hi_cur, lo_cur} + prod_u;
      OP_MSUB:  {res_hi, res_lo} = {hi_cur, lo_cur} - prod_s;
      OP_MSUBU: {res_hi, res_lo} = {hi_cur, lo_cur} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu_param.sv
// rtl/e_mdu_param.sv - E-stage multi-cycle multiply/divide unit with HI/LO and cancel
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (codes 9-12).
module e_mdu_param
  import mdu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        mdu_ctr,
  input  logic              start,
  input  logic              cancel,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy
);

  localparam int CW = lat_w(MULT_LAT, DIV_LAT);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] pend_hi, pend_lo;
  logic [DATA_W-1:0] calc_hi, calc_lo;
  logic              launch_op, div_op;

  always_comb begin
    div_op = (mdu_ctr == OP_DIV) || (mdu_ctr == OP_DIVU);
    launch_op = (mdu_ctr == OP_MULT) || (mdu_ctr == OP_MULTU) || div_op;
`ifdef MDU_MADD_EN
    launch_op = launch_op || (mdu_ctr == OP_MADD) || (mdu_ctr == OP_MADDU) ||
                (mdu_ctr == OP_MSUB) || (mdu_ctr == OP_MSUBU);
`endif
  end

  mdu_core_calc #(.DATA_W(DATA_W)) u_calc (
    .a      (a),
    .b      (b),
    .op     (mdu_ctr),
    .hi_cur (hi),
    .lo_cur (lo),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  // Result is frozen at launch; HI/LO only move when the counter expires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!cancel) begin
            if (start && launch_op) begin
              state   <= RUN;
              busy    <= 1'b1;
              cnt     <= div_op ? CW'(DIV_LAT) : CW'(MULT_LAT);
              pend_hi <= calc_hi;
              pend_lo <= calc_lo;
            end else if (mdu_ctr == OP_MTHI) begin
              hi <= a;
            end else if (mdu_ctr == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            hi    <= pend_hi;
            lo    <= pend_lo;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu_param.sv
// tb/tb_e_mdu_param.sv - directed and randomized bench for e_mdu_param (MDU_MADD_EN aware)
module tb_e_mdu_param;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  mdu_ctr;
  logic        start, cancel;
  logic [31:0] hi, lo;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;

  e_mdu_param #(.DATA_W(32), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .mdu_ctr (mdu_ctr),
    .start   (start),
    .cancel  (cancel),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed division done on magnitudes in 64-bit arithmetic, signs applied afterwards.
  task automatic ref_calc(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] h, input logic [31:0] l,
                          output bit launch, output int lat,
                          output logic [31:0] rh, output logic [31:0] rl);
    longint sx, sy, mx, my, q, r;
    longint unsigned ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    rh = h;
    rl = l;
    launch = 0;
    lat = 0;
    p = '0;
    case (op)
      4'd1: begin launch = 1; lat = MULT_LAT; p = sx * sy; {rh, rl} = p; end
      4'd2: begin launch = 1; lat = MULT_LAT; p = ux * uy; {rh, rl} = p; end
      4'd3: begin
        launch = 1; lat = DIV_LAT;
        if (y != 0) begin
          mx = (sx < 0) ? -sx : sx;
          my = (sy < 0) ? -sy : sy;
          q = mx / my;
          r = mx - q * my;
          if ((sx < 0) != (sy < 0)) q = -q;
          if (sx < 0) r = -r;
          rl = q[31:0];
          rh = r[31:0];
        end
      end
      4'd4: begin
        launch = 1; lat = DIV_LAT;
        if (y != 0) begin
          p = ux / uy; rl = p[31:0];
          p = ux % uy; rh = p[31:0];
        end
      end
      4'd7: rh = x;
      4'd8: rl = x;
`ifdef MDU_MADD_EN
      4'd9:  begin launch = 1; lat = MULT_LAT; p = sx * sy; {rh, rl} = {h, l} + p; end
      4'd10: begin launch = 1; lat = MULT_LAT; p = ux * uy; {rh, rl} = {h, l} + p; end
      4'd11: begin launch = 1; lat = MULT_LAT; p = sx * sy; {rh, rl} = {h, l} - p; end
      4'd12: begin launch = 1; lat = MULT_LAT; p = ux * uy; {rh, rl} = {h, l} - p; end
`endif
      default: ;
    endcase
  endtask

  // cancel_at: busy cycle (1-based) during which cancel is raised; larger than latency means never.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int cancel_at, input string tag);
    bit launch;
    int lat;
    logic [31:0] rh, rl;
    ref_calc(op, x, y, m_hi, m_lo, launch, lat, rh, rl);
    @(negedge clk);
    mdu_ctr = op; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mdu_ctr = 4'd0;
    if (!launch) begin
      m_hi = rh; m_lo = rl;
      @(negedge clk);
      chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
      chk({tag, ".hi"}, hi, m_hi);
      chk({tag, ".lo"}, lo, m_lo);
      return;
    end
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk({tag, ".busy_run"}, {31'b0, busy}, 32'd1);
      chk({tag, ".hi_run"}, hi, m_hi);
      chk({tag, ".lo_run"}, lo, m_lo);
      if (i == cancel_at) begin
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk({tag, ".busy_cxl"}, {31'b0, busy}, 32'd0);
        chk({tag, ".hi_cxl"}, hi, m_hi);
        chk({tag, ".lo_cxl"}, lo, m_lo);
        return;
      end
    end
    @(negedge clk);
    m_hi = rh; m_lo = rl;
    chk({tag, ".busy_done"}, {31'b0, busy}, 32'd0);
    chk({tag, ".hi"}, hi, m_hi);
    chk({tag, ".lo"}, lo, m_lo);
  endtask

  initial begin
    logic [3:0]  op_tab [14];
    logic [3:0]  op;
    logic [31:0] x, y;
    int sel, cx;

    op_tab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd9, 4'd10, 4'd11, 4'd12, 4'd14};
    reset = 1'b1; a = 0; b = 0; mdu_ctr = 0; start = 0; cancel = 0;
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    reset = 1'b0;

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 99, "mult");
    chk("mult.hi_const", hi, 32'hFFFFFFFF);
    chk("mult.lo_const", lo, 32'hFFFFFFFA);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 99, "div");
    chk("div.hi_const", hi, 32'hFFFFFFFF);
    chk("div.lo_const", lo, 32'hFFFFFFFD);
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, 99, "divu");
    chk("divu.hi_const", hi, 32'd1);
    chk("divu.lo_const", lo, 32'h7FFFFFFC);

    run_op(4'd7, 32'h11, 32'd0, 99, "mthi");
    run_op(4'd8, 32'h22, 32'd0, 99, "mtlo");
    run_op(4'd3, 32'h1234, 32'd0, 99, "div0");
    chk("div0.hi_const", hi, 32'h11);
    chk("div0.lo_const", lo, 32'h22);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 99, "divovf");
    chk("divovf.hi_const", hi, 32'd0);
    chk("divovf.lo_const", lo, 32'h80000000);

    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, "multu_cxl");
    repeat (MULT_LAT) @(negedge clk);
    chk("cxl.late_hi", hi, m_hi);
    chk("cxl.late_lo", lo, m_lo);

    // start and cancel together; likewise cancel masks an MTHI
    @(negedge clk);
    mdu_ctr = 4'd1; a = 32'd7; b = 32'd9; start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mdu_ctr = 4'd7; a = 32'hDEAD;
    @(posedge clk);
    #1 cancel = 1'b0; mdu_ctr = 4'd0;
    for (int i = 0; i < MULT_LAT + 1; i++) begin
      @(negedge clk);
      chk("sc.busy", {31'b0, busy}, 32'd0);
    end
    chk("sc.hi", hi, m_hi);
    chk("sc.lo", lo, m_lo);

    // asynchronous reset in busy cycle 2 of a divide
    @(negedge clk);
    mdu_ctr = 4'd4; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mdu_ctr = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rmid.busy_pre", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rmid.busy", {31'b0, busy}, 32'd0);
    chk("rmid.hi", hi, 32'd0);
    chk("rmid.lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    repeat (DIV_LAT + 2) @(negedge clk);
    chk("rmid.late_busy", {31'b0, busy}, 32'd0);
    chk("rmid.late_hi", hi, 32'd0);
    chk("rmid.late_lo", lo, 32'd0);

`ifdef MDU_MADD_EN
    run_op(4'd7, 32'd0, 32'd0, 99, "mthi0");
    run_op(4'd8, 32'hFFFFFFFF, 32'd0, 99, "mtlo1");
    run_op(4'd10, 32'd1, 32'd1, 99, "maddu");
    chk("maddu.hi_const", hi, 32'd1);
    chk("maddu.lo_const", lo, 32'd0);
    run_op(4'd8, 32'd0, 32'd0, 99, "mtlo0");
    run_op(4'd7, 32'd0, 32'd0, 99, "mthi0b");
    run_op(4'd11, 32'd2, 32'd3, 99, "msub");
    chk("msub.hi_const", hi, 32'hFFFFFFFF);
    chk("msub.lo_const", lo, 32'hFFFFFFFA);
`else
    run_op(4'd9, 32'd5, 32'd6, 99, "madd_off");
    chk("madd_off.hi_const", hi, 32'd0);
    chk("madd_off.lo_const", lo, 32'd0);
`endif

    for (int it = 0; it < 60; it++) begin
      op = op_tab[$urandom_range(0, 13)];
      x = $urandom;
      y = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      else if (sel == 2) begin x = $urandom_range(0, 50); y = $urandom_range(1, 9); end
      else if (sel == 3) y = -$urandom_range(1, 9);
      cx = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 99;
      run_op(op, x, y, cx, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/e_mdu_param.md
Name: e_mdu_param

Overview:
- Parametrised multi-cycle multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Successor to the fixed 32-bit MDU. Adds:
  - width and per-operation latency generics
  - a cancel input for upcoming exception/flush support
  - a defined divide-by-zero and overflow policy
  - optional multiply-accumulate
- Holds architectural HI/LO. The hazard unit stalls D while start or busy is high and an MDU instruction sits in D.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- MULT_LAT, 5, busy cycles for mult/multu/madd*/msub* (≥1).
- DIV_LAT, 10, busy cycles for div/divu (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- a  in  DATA_W  rs operand (forwarded).
- b  in  DATA_W  rt operand (forwarded).
- mdu_ctr  in  4  operation code (package mdu_op_t).
- start  in  1  one-cycle pulse launching a mult/div-class op; sampled with mdu_ctr.
- cancel  in  1  flush: aborts the in-flight op and suppresses a same-cycle start or mt* write.
- hi  out  DATA_W  architectural HI.
- lo  out  DATA_W  architectural LO.
- busy  out  1  operation in flight.

Behaviour:
- Op codes:
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
  - 9–12 MADD/MADDU/MSUB/MSUBU (optional; see below).
  - All other codes behave as NOP.
- Reset: hi=0, lo=0, busy=0, counter=0, state IDLE, pending result cleared. Reset mid-operation discards the pending result.
- FSM states:
  - IDLE → RUN: start & !cancel & mult/div-class op.
  - RUN → IDLE: counter==1 at a clock edge, or cancel.
- Operand capture and latency:
  - On the launching edge, the result is computed from a, b, mdu_ctr and latched into pend_hi/pend_lo.
  - Counter loads MULT_LAT or DIV_LAT.
  - busy is registered: it rises the cycle after start and stays high exactly LAT cycles.
  - hi/lo are written on the edge that ends the last busy cycle, so new values are visible the first cycle busy=0.
- During RUN, hi/lo keep their old values.
- start in RUN is ignored (the hazard unit guarantees it does not occur).
- cancel in RUN: busy drops next cycle and hi/lo are unchanged.
- MTHI/MTLO:
  - In IDLE with !cancel, hi (or lo) ← a on the next edge. No busy.
  - In RUN, ignored.
- MFHI/MFLO: no state change; the datapath reads hi/lo combinationally.
- Arithmetic:
  - MULT: signed 2·DATA_W product. MULTU: unsigned product. hi = upper half, lo = lower half.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (b==0): full latency still applies; hi/lo unchanged on completion.
  - Signed overflow (−2^(DATA_W−1) / −1): lo = −2^(DATA_W−1), hi = 0.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - Codes 9–12 are valid mult-class ops with latency MULT_LAT.
  - {hi,lo} ← {hi,lo} ± product, signed for 9/11 and unsigned for 10/12, modulo 2^(2·DATA_W).
  - The accumulator base {hi,lo} is sampled at launch.
- Undefined: codes 9–12 are NOP; no adder hardware is generated.

Decomposition:
- Shared package mdu_pkg holds:
  - mdu_op_t enum (4-bit codes above)
  - state_t {IDLE, RUN}
  - function lat_w(MULT_LAT, DIV_LAT) = $clog2(max+1) for the counter width
- One natural sub-module, mdu_core_calc: purely combinational function computing {pend_hi, pend_lo} from a, b, op and the current hi/lo. This keeps the arithmetic separate from the FSM/counter shell.

Test Plan:
- MULT a=0xFFFFFFFE (−2), b=3, start at cycle 0 (MULT_LAT=5):
  - busy=1 in cycles 1–5 and 0 at cycle 6.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA at cycle 6; old values during cycles 1–5.
- DIV a=−7 (0xFFFFFFF9), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. DIVU on the same operands: lo=0x7FFFFFFC, hi=1.
- Divide-by-zero and overflow:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV b=0: busy 10 cycles, hi/lo stay 0x11/0x22.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Cancel:
  - MULTU 0xFFFFFFFF×0xFFFFFFFF, cancel at busy cycle 3: busy=0 next cycle, hi/lo unchanged.
  - start+cancel in the same cycle: busy never rises.
- Reset mid-operation: assert reset asynchronously during busy cycle 2 of a DIV. Immediately busy=0, hi=lo=0, and no late write after reset deasserts.
- With MDU_MADD_EN defined:
  - hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0.
  - MSUB 2×3 from {0,0} → hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Without the macro, code 9 leaves busy=0 and hi/lo unchanged.
